// File: rtl/fp_unpack_classify.sv
// Unpacks an IEEE-754 word into sign, unbiased exponent, normalized significand and class.
// Build option FP_UNPACK_FASTNORM_EN: normalize subnormals in one cycle (LZC + barrel shift) instead of 1 bit/cycle.
//
// state | meaning
// IDLE  | no result held, ready for a word
// NORM  | left-shifting a subnormal significand until the hidden bit is set (iterative build only)
// DONE  | result presented on out_*, held until out_ready
module fp_unpack_classify #(
    parameter int EXPONENT_BITS = 8,
    parameter int FRACTION_BITS = 23
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [EXPONENT_BITS+FRACTION_BITS:0]     in_bits,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_sign,
    output logic signed [EXPONENT_BITS+1:0]          out_exponent,
    output logic [FRACTION_BITS:0]                   out_significand,
    output logic [2:0]                               out_class
);
    localparam int E    = EXPONENT_BITS;
    localparam int F    = FRACTION_BITS;
    localparam int XW   = E + 2;
    localparam int BIAS = 2**(E-1) - 1;

    localparam logic [2:0] CLS_ZERO      = 3'd0;
    localparam logic [2:0] CLS_SUBNORMAL = 3'd1;
    localparam logic [2:0] CLS_NORMAL    = 3'd2;
    localparam logic [2:0] CLS_INF       = 3'd3;
    localparam logic [2:0] CLS_QNAN      = 3'd4;
    localparam logic [2:0] CLS_SNAN      = 3'd5;

`ifdef FP_UNPACK_FASTNORM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t state, state_nx, load_state;

    logic         in_sign;
    logic [E-1:0] in_exp;
    logic [F-1:0] in_frac;
    logic         exp_zero, exp_ones, frac_zero;
    logic         accept;

    logic [2:0]          dec_class;
    logic signed [XW-1:0] dec_exp;
    logic [F:0]          dec_sig;

    assign {in_sign, in_exp, in_frac} = in_bits;
    assign exp_zero  = (in_exp == '0);
    assign exp_ones  = &in_exp;
    assign frac_zero = (in_frac == '0);
    assign accept    = in_valid && in_ready;

`ifdef FP_UNPACK_FASTNORM_EN
    localparam int LZW = $clog2(F + 1);
    logic [LZW-1:0] lz;
    logic           lz_hit;

    always_comb begin
        lz     = '0;
        lz_hit = 1'b0;
        for (int i = F - 1; i >= 0; i--) begin
            if (!lz_hit) begin
                if (in_frac[i]) lz_hit = 1'b1;
                else            lz     = lz + LZW'(1);
            end
        end
    end

    assign load_state = DONE;
`else
    logic dec_norm;
    assign load_state = dec_norm ? NORM : DONE;
`endif

    always_comb begin
        dec_class = CLS_NORMAL;
        dec_sig   = {1'b1, in_frac};
        dec_exp   = XW'(int'(in_exp) - BIAS);
`ifndef FP_UNPACK_FASTNORM_EN
        dec_norm  = 1'b0;
`endif
        if (exp_zero && frac_zero) begin
            dec_class = CLS_ZERO;
            dec_sig   = '0;
            dec_exp   = '0;
        end else if (exp_zero) begin
            dec_class = CLS_SUBNORMAL;
`ifdef FP_UNPACK_FASTNORM_EN
            // Shift = leading zeros + 1 brings the top set bit into the hidden position.
            dec_sig   = {1'b0, in_frac} << (lz + LZW'(1));
            dec_exp   = XW'(-BIAS - int'(lz));
`else
            dec_sig   = {1'b0, in_frac};
            dec_exp   = XW'(1 - BIAS);
            dec_norm  = 1'b1;
`endif
        end else if (exp_ones) begin
            dec_exp = '0;
            if (frac_zero) begin
                dec_class = CLS_INF;
                dec_sig   = '0;
            end else begin
                dec_class = in_frac[F-1] ? CLS_QNAN : CLS_SNAN;
                dec_sig   = {1'b0, in_frac};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = load_state;
`ifndef FP_UNPACK_FASTNORM_EN
            // Leave after the shift that lands the top bit in the hidden position.
            NORM: if (out_significand[F-1]) state_nx = DONE;
`endif
            DONE: begin
                if (accept)         state_nx = load_state;
                else if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_sign        <= 1'b0;
            out_exponent    <= '0;
            out_significand <= '0;
            out_class       <= CLS_ZERO;
        end else if (accept) begin
            out_sign        <= in_sign;
            out_exponent    <= dec_exp;
            out_significand <= dec_sig;
            out_class       <= dec_class;
`ifndef FP_UNPACK_FASTNORM_EN
        end else if (state == NORM) begin
            out_significand <= out_significand << 1;
            out_exponent    <= out_exponent - XW'(1);
`endif
        end
    end

endmodule

// File: tb/tb_fp_unpack_classify.sv
// Scoreboard bench for fp_unpack_classify (single precision): directed cases plus randomized words
// checked against an arithmetic reference model; a monitor pops expectations on each handshake.
module tb_fp_unpack_classify;
    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_bits = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_sign;
    logic signed [9:0] out_exponent;
    logic [23:0]       out_significand;
    logic [2:0]        out_class;

    fp_unpack_classify #(.EXPONENT_BITS(8), .FRACTION_BITS(23)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_bits         (in_bits),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sign        (out_sign),
        .out_exponent    (out_exponent),
        .out_significand (out_significand),
        .out_class       (out_class)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic sign;
        int   exp;
        int   sig;
        int   cls;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low

`ifdef FP_UNPACK_FASTNORM_EN
    localparam int SUB_LAT_1 = 1;
`else
    localparam int SUB_LAT_1 = 24;
`endif

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    // Reference: value-level decode using plain arithmetic on the fields.
    function automatic exp_t model(input logic [31:0] w);
        exp_t r;
        int e = int'(w[30:23]);
        int f = int'(w[22:0]);
        int p;
        r.sign = w[31];
        r.exp  = 0;
        r.sig  = 0;
        if (e == 0 && f == 0) begin
            r.cls = 0;
        end else if (e == 0) begin
            p     = $clog2(f + 1) - 1;     // position of highest set bit
            r.cls = 1;
            r.sig = f * (1 << (23 - p));
            r.exp = -126 - (23 - p);
        end else if (e == 255) begin
            if (f == 0) r.cls = 3;
            else begin
                r.cls = (f >= (1 << 22)) ? 4 : 5;
                r.sig = f;
            end
        end else begin
            r.cls = 2;
            r.sig = (1 << 23) + f;
            r.exp = e - 127;
        end
        return r;
    endfunction

    always @(negedge clock) begin
        case (rdy_mode)
            0:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic        hold_pending = 1'b0;
    logic [37:0] hold_snap = '0;

    always @(negedge clock) begin
        exp_t e;
        #2;
        if (!reset_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({out_sign, out_exponent, out_significand, out_class}), 64'(hold_snap));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got class %0d exp %0d with nothing pending, expected no output", out_class, out_exponent);
                end else begin
                    e = sbq.pop_front();
                    check("sb_sign", 64'(out_sign), 64'(e.sign));
                    check("sb_exp", 64'(out_exponent), 64'(e.exp));
                    check("sb_sig", 64'(out_significand), 64'(e.sig));
                    check("sb_class", 64'(out_class), 64'(e.cls));
                end
            end
            hold_pending = out_valid && !out_ready;
            hold_snap    = {out_sign, out_exponent, out_significand, out_class};
        end
    end

    // Called at negedge+1; returns at negedge+1 of the cycle after acceptance.
    task automatic send(input logic [31:0] w);
        int guard = 0;
        in_valid = 1'b1;
        in_bits  = w;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            #1;
            guard++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", guard);
        end else begin
            sbq.push_back(model(w));
        end
        @(negedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        case (k)
            0:       w[30:0]  = '0;
            1, 2, 3: w[30:23] = 8'h00;
            4: begin w[30:23] = 8'hFF; w[22:0] = '0; end
            5, 6:    w[30:23] = 8'hFF;
            7: begin w[30:23] = 8'h00; w[22:0] = 23'(1) << $urandom_range(0, 22); end
            default: ;
        endcase
        return w;
    endfunction

    logic [31:0] spec_w [4]   = '{32'h80000000, 32'hFF800000, 32'h7FC00000, 32'h7F800001};
    int          spec_cls [4] = '{0, 3, 4, 5};
    int          spec_sgn [4] = '{1, 1, 0, 0};
    int          spec_sig [4] = '{0, 0, 32'h400000, 1};

    initial begin
        int lat;
        int guard;
        logic [31:0] w;

        rdy_mode = 0;
        reset_n  = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", 64'({out_sign, out_exponent, out_significand, out_class}), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        #1;

        send(32'h3F800000);
        check("one_latency", 64'(out_valid), 64'd1);
        check("one_exp", 64'(out_exponent), 64'sd0);
        check("one_sig", 64'(out_significand), 64'h800000);
        check("one_class", 64'(out_class), 64'd2);

        send(32'h00000001);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clock);
            #1;
            lat++;
        end
        check("sub_latency", 64'(lat), 64'(SUB_LAT_1));
        check("sub_exp", 64'(out_exponent), -64'sd149);
        check("sub_sig", 64'(out_significand), 64'h800000);
        check("sub_class", 64'(out_class), 64'd1);
        @(negedge clock);
        #1;

        for (int i = 0; i < 4; i++) begin
            send(spec_w[i]);
            check("special_class", 64'(out_class), 64'(spec_cls[i]));
            check("special_sign", 64'(out_sign), 64'(spec_sgn[i]));
            check("special_sig", 64'(out_significand), 64'(spec_sig[i]));
        end

        rdy_mode = 2;
        @(negedge clock);
        #1;
        send(32'h40490FDB);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_exp", 64'(out_exponent), 64'sd1);
            check("stall_sig", 64'(out_significand), 64'hC90FDB);
            @(negedge clock);
            #1;
        end
        rdy_mode = 0;
        @(negedge clock);
        #1;
        check("release_handshake", 64'({out_valid, out_ready}), 64'b11);
        @(negedge clock);
        #1;
        check("release_idle_valid", 64'(out_valid), 64'd0);
        check("release_idle_ready", 64'(in_ready), 64'd1);

        send(32'h00000001);
        repeat (5) begin
            @(negedge clock);
            #1;
        end
`ifndef FP_UNPACK_FASTNORM_EN
        check("norm_busy_ready", 64'(in_ready), 64'd0);
        check("norm_busy_valid", 64'(out_valid), 64'd0);
`endif
        reset_n = 1'b0;
        sbq.delete();
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_outputs", 64'({out_sign, out_exponent, out_significand, out_class}), 64'd0);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (30) @(negedge clock);
        #1;
        check("midrst_no_stale", 64'(out_valid), 64'd0);

        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            if (w[30:23] == 8'h00 || w[30:23] == 8'hFF) w[30:23] = 8'h80;
            send(w);
            check("b2b_valid", 64'(out_valid), 64'd1);
        end

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(rand_word());
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                #1;
            end
        end

        rdy_mode = 0;
        guard = 0;
        while (sbq.size() != 0 && guard < 100) begin
            @(negedge clock);
            #1;
            guard++;
        end
        @(negedge clock);
        #3;
        check("drain_pending", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
